// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch addresses, tracks one-cycle memory latency,
// and presents instructions to decode with stall replay and redirect squash.
// Optional performance counters are enabled by defining IFU_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruct,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        if_valid,
  output logic [31:0] if_instruct,
  output logic [31:0] if_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [31:0] Span = 32'(IMEM_WORDS * 4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] redir_pc;
  logic        replay;

  // Aligned and folded into the memory range so imem_addr never leaves it.
  assign redir_pc = (redirect_addr & ~32'h3) % Span;
  assign replay   = resp_valid_q & stall;

  assign if_instruct = imem_instruct;
  assign if_pc       = resp_pc_q;
  assign if_valid    = rst & resp_valid_q & ~redirect_valid;

  always_comb begin
    imem_addr    = pc_q;
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    if (!rst) begin
      imem_addr = RESET_PC;
    end else if (redirect_valid) begin
      imem_addr    = redir_pc;
      resp_pc_d    = redir_pc;
      resp_valid_d = 1'b1;
      pc_d         = (redir_pc + 32'd4) % Span;
    end else if (replay) begin
      // Re-read the held address so imem_instruct stays valid next cycle.
      imem_addr = resp_pc_q;
    end else begin
      imem_addr    = pc_q;
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
      pc_d         = (pc_q + 32'd4) % Span;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      resp_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (if_valid && !stall) fetch_count_q <= fetch_count_q + 32'd1;
      if (if_valid && stall)  stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
